// File: rtl/backplane_frame_buffer_pkg.sv
// Shared types and sizing helpers for the backplane frame buffer.
// Default geometry and write-side state encoding.
package backplane_frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } wr_state_t;

    localparam int DEF_DEPTH     = 2048;
    localparam int DEF_LEN_DEPTH = 16;
    localparam int DEF_MAX_LEN   = 512;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/backplane_frame_buffer_if.sv
// Byte capture, frame read and status signals of the frame buffer.
// master drives bytes and reads; slave is the buffer itself.
interface backplane_frame_buffer_if #(
    parameter int LW = 10
) ();
    logic [7:0]    byte_in;
    logic          byte_rdy;
    logic          bus_idle;
    logic          frame_avail;
    logic [LW-1:0] frame_len;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          frame_ack;
    logic [15:0]   drop_count;
    logic          overflow;

    modport master (
        output byte_in, byte_rdy, bus_idle, rd_en, frame_ack,
        input  frame_avail, frame_len, rd_data, rd_valid,
        input  drop_count, overflow
    );

    modport slave (
        input  byte_in, byte_rdy, bus_idle, rd_en, frame_ack,
        output frame_avail, frame_len, rd_data, rd_valid,
        output drop_count, overflow
    );
endinterface

// File: rtl/backplane_frame_buffer_len_fifo.sv
// Synchronous FIFO holding the byte length of each committed frame.
// Head entry is presented combinationally; caller never pushes when full.
module frame_len_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q;
    logic [PW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (wr_q - rd_q) == FULL_CNT;
    assign empty_o = wr_q == rd_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[PW-1:0]];

    // Pointer update; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Length storage, no reset needed: empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
    end
endmodule

// File: rtl/backplane_frame_buffer.sv
// Frames sampled backplane bytes into a ring buffer plus length FIFO.
// Overlong or unstorable frames are rolled back and counted.
module backplane_frame_buffer
    import backplane_frame_buffer_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LEN_DEPTH = DEF_LEN_DEPTH,
    parameter int MAX_LEN   = DEF_MAX_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    backplane_frame_buffer_if.slave  bus
);
    localparam int AW = addr_width(DEPTH);
    localparam int LW = len_width(MAX_LEN);
    localparam logic [AW:0]   RING_FULL = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] LEN_LIMIT = LW'(MAX_LEN);

    wr_state_t     state_q;
    logic          byte_rdy_q;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   frame_start_q;
    logic [LW-1:0] cur_len_q;
    logic [15:0]   drop_q;
    logic          ovf_q;

    logic [AW:0]   rd_base_q;
    logic [AW:0]   rd_ptr_q;
    logic [LW-1:0] rd_cnt_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;

    logic [7:0]    mem [DEPTH];

    logic          stb;
    logic [AW:0]   used;
    logic          ring_full;
    logic          len_max;
    logic          wr_en;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] head_len;
    logic          rd_ok;
    logic          ack_ok;
    logic [AW:0]   next_base;

    assign stb       = bus.byte_rdy && !byte_rdy_q && !bus.bus_idle;
    assign used      = wr_ptr_q - rd_base_q;
    assign ring_full = used == RING_FULL;
    assign len_max   = cur_len_q == LEN_LIMIT;
    assign wr_en     = stb && !ring_full &&
                       ((state_q == IDLE) ||
                        (state_q == RECV && !len_max));
    assign push      = (state_q == RECV) && bus.bus_idle && !fifo_full;

    assign rd_ok     = bus.rd_en && !fifo_empty && (rd_cnt_q < head_len);
    assign ack_ok    = bus.frame_ack && !fifo_empty;
    assign next_base = rd_base_q + (AW+1)'(head_len);

    frame_len_fifo #(
        .W     (LW),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (cur_len_q),
        .pop_i   (ack_ok),
        .dout_o  (head_len),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Rising-edge history of byte_rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) byte_rdy_q <= 1'b0;
        else     byte_rdy_q <= bus.byte_rdy;
    end

    // Write FSM: collect bytes, commit on idle, roll back on discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            cur_len_q     <= '0;
            drop_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (stb) begin
                        frame_start_q <= wr_ptr_q;
                        if (ring_full) begin
                            state_q <= DROP;
                        end else begin
                            wr_ptr_q  <= wr_ptr_q + 1'b1;
                            cur_len_q <= LW'(1);
                            state_q   <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (bus.bus_idle) begin
                        if (fifo_full) begin
                            wr_ptr_q <= frame_start_q;
                            ovf_q    <= 1'b1;
                            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                        end
                        state_q <= IDLE;
                    end else if (stb) begin
                        if (ring_full || len_max) begin
                            state_q <= DROP;
                        end else begin
                            wr_ptr_q  <= wr_ptr_q + 1'b1;
                            cur_len_q <= cur_len_q + LW'(1);
                        end
                    end
                end
                DROP: begin
                    if (bus.bus_idle) begin
                        wr_ptr_q <= frame_start_q;
                        ovf_q    <= 1'b1;
                        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ring storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= bus.byte_in;
    end

    // Read side: pop a byte of the head frame, then retire on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_base_q  <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_cnt_q  <= rd_cnt_q + LW'(1);
            end
            if (ack_ok) begin
                rd_base_q <= next_base;
                rd_ptr_q  <= next_base;
                rd_cnt_q  <= '0;
            end
        end
    end

    assign bus.frame_avail = !fifo_empty;
    assign bus.frame_len   = fifo_empty ? '0 : head_len;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.drop_count  = drop_q;
    assign bus.overflow    = ovf_q;
endmodule
